// File: rtl/wb_regfile_stage_pkg.sv
// Shared widths and writeback-select encoding for the writeback / register-file stage.
package wb_regfile_stage_pkg;

  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  // Source of the value written back to the register file.
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2
  } wb_sel_e;

  // The link value (pc + 2) outranks memory data, which outranks the ALU result.
  function automatic wb_sel_e wb_select(input logic towrite, input logic memtoreg);
    if (towrite) begin
      return WB_SEL_LINK;
    end else if (memtoreg) begin
      return WB_SEL_MEM;
    end
    return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/dff_pipe.sv
// Generic enabled pipeline register with synchronous clear (reset or flush) and stall hold.
module dff_pipe #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              stall,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear on reset or flush; otherwise load when enabled and not stalled.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= '0;
    end else if (en && !stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// Register array with one write port and two combinational read ports; a read of the
// register being written this cycle returns the incoming write data.
module regfile_bypass #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic wr_en;
    assign wr_en = we && (wr_addr == ADDR_W'(i));
    dff_pipe #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .rst   (rst),
      .en    (wr_en),
      .flush (1'b0),
      .stall (1'b0),
      .d     (wr_data),
      .q     (regs[i])
    );
  end

  // Both ports use the same bypass rule, so equal addresses always read equal data.
  always_comb begin
    rs_data = (we && (rs_addr == wr_addr)) ? wr_data : regs[rs_addr];
    rt_data = (we && (rt_addr == wr_addr)) ? wr_data : regs[rt_addr];
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// and keeps the sticky halt flag plus cycle / write counters.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  REGWRITE_wb,
  input  logic                  MEMTOREG_wb,
  input  logic                  TOWRITEDATA_wb,
  input  logic                  HALT_wb,
  input  logic [REG_ADDR_W-1:0] Rd_wb,
  input  logic [REG_W-1:0]      alu_out_wb,
  input  logic [REG_W-1:0]      memData_out_wb,
  input  logic [REG_W-1:0]      pc_add2_wb,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [REG_W-1:0]      rs_data,
  output logic [REG_W-1:0]      rt_data,
  output logic [REG_W-1:0]      wb_data,
  output logic                  wb_we,
  output logic                  halted,
  output logic [REG_W-1:0]      cycle_cnt,
  output logic [REG_W-1:0]      wr_cnt
);

  wb_sel_e wb_sel;

  // Zero-latency writeback mux and write enable, also used for EX forwarding.
  always_comb begin
    wb_sel = wb_select(TOWRITEDATA_wb, MEMTOREG_wb);
    unique case (wb_sel)
      WB_SEL_LINK: wb_data = pc_add2_wb;
      WB_SEL_MEM:  wb_data = memData_out_wb;
      default:     wb_data = alu_out_wb;
    endcase
    wb_we = REGWRITE_wb && !halted;
  end

  regfile_bypass #(
    .DATA_W   (REG_W),
    .ADDR_W   (REG_ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .wr_addr (Rd_wb),
    .wr_data (wb_data),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  // Halt flag and counters; the halting cycle itself still counts, then everything freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted    <= 1'b0;
      cycle_cnt <= '0;
      wr_cnt    <= '0;
    end else if (!halted) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (wb_we) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (HALT_wb) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: hand-computed vector table, directed corner sequences,
// and randomized traffic checked against a behavioural model every cycle.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite, memtoreg, towrite, halt;
  logic [2:0]  rd, rs_addr, rt_addr;
  logic [15:0] alu, mem, pc;
  logic [15:0] rs_data, rt_data, wb_data, cycle_cnt, wr_cnt;
  logic        wb_we, halted;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [15:0] m_regs [8];
  bit          m_halted;
  int          m_cyc, m_wr;
  bit          m_valid = 0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk            (clk),
    .rst            (rst),
    .REGWRITE_wb    (regwrite),
    .MEMTOREG_wb    (memtoreg),
    .TOWRITEDATA_wb (towrite),
    .HALT_wb        (halt),
    .Rd_wb          (rd),
    .alu_out_wb     (alu),
    .memData_out_wb (mem),
    .pc_add2_wb     (pc),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .wb_data        (wb_data),
    .wb_we          (wb_we),
    .halted         (halted),
    .cycle_cnt      (cycle_cnt),
    .wr_cnt         (wr_cnt)
  );

  typedef struct {
    logic        rw, m2r, tw;
    logic [2:0]  rd;
    logic [15:0] alu, mem, pc;
    logic [2:0]  rs, rt;
    logic [15:0] exp_wb, exp_rs, exp_rt;
    logic        exp_we;
    logic [15:0] exp_wr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rw, input logic m2r, input logic tw,
                       input logic h, input logic [2:0] d, input logic [15:0] a,
                       input logic [15:0] m, input logic [15:0] p,
                       input logic [2:0] s, input logic [2:0] t);
    rst = r; regwrite = rw; memtoreg = m2r; towrite = tw; halt = h; rd = d;
    alu = a; mem = m; pc = p; rs_addr = s; rt_addr = t;
  endtask

  function automatic logic [15:0] model_wb();
    if (towrite) return pc;
    if (memtoreg) return mem;
    return alu;
  endfunction

  // Called just after a falling edge with inputs already applied; returns after the next falling edge.
  task automatic tick();
    logic [15:0] wbv;
    logic        wev;
    #1;
    wbv = model_wb();
    wev = regwrite && !m_halted;
    if (m_valid) begin
      chk("wb_data", wb_data, wbv);
      chk("wb_we", {15'd0, wb_we}, {15'd0, wev});
      chk("rs_data", rs_data, (wev && rs_addr == rd) ? wbv : m_regs[rs_addr]);
      chk("rt_data", rt_data, (wev && rt_addr == rd) ? wbv : m_regs[rt_addr]);
    end
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0000;
      m_halted = 0; m_cyc = 0; m_wr = 0; m_valid = 1;
    end else if (!m_halted) begin
      m_cyc = (m_cyc + 1) % 65536;
      if (regwrite) begin
        m_regs[rd] = wbv;
        m_wr = (m_wr + 1) % 65536;
      end
      if (halt) m_halted = 1;
    end
    #1;
    if (m_valid) begin
      chk("halted", {15'd0, halted}, {15'd0, m_halted});
      chk("cycle_cnt", cycle_cnt, 16'(m_cyc));
      chk("wr_cnt", wr_cnt, 16'(m_wr));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Hand-computed vectors, applied back-to-back from a fresh reset.
    vecs[0] = '{1,0,0, 3'd1, 16'h1111,16'h2222,16'h3333, 3'd1,3'd2, 16'h1111,16'h1111,16'h0000, 1, 16'd1};
    vecs[1] = '{1,1,0, 3'd2, 16'h4444,16'h5555,16'h6666, 3'd1,3'd2, 16'h5555,16'h1111,16'h5555, 1, 16'd2};
    vecs[2] = '{1,1,1, 3'd3, 16'h9999,16'h1111,16'h0042, 3'd3,3'd1, 16'h0042,16'h0042,16'h1111, 1, 16'd3};
    vecs[3] = '{0,0,0, 3'd1, 16'hDEAD,16'h0000,16'h0000, 3'd1,3'd3, 16'hDEAD,16'h1111,16'h0042, 0, 16'd3};
    vecs[4] = '{1,0,1, 3'd0, 16'h0000,16'h0000,16'h00AA, 3'd0,3'd0, 16'h00AA,16'h00AA,16'h00AA, 1, 16'd4};
    vecs[5] = '{0,0,0, 3'd5, 16'h0001,16'h0000,16'h0000, 3'd0,3'd2, 16'h0001,16'h00AA,16'h5555, 0, 16'd4};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Reset state: all registers zero, flags and counters cleared.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'(i), 3'(i));
      #1;
      chk("reset_reg_rs", rs_data, 16'h0000);
      chk("reset_reg_rt", rt_data, 16'h0000);
      tick();
    end
    chk("reset_halted", {15'd0, halted}, 16'd0);
    chk("reset_wr_cnt", wr_cnt, 16'h0000);

    // Vector table.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, vecs[i].rw, vecs[i].m2r, vecs[i].tw, 0, vecs[i].rd,
            vecs[i].alu, vecs[i].mem, vecs[i].pc, vecs[i].rs, vecs[i].rt);
      #1;
      chk("tbl_wb_data", wb_data, vecs[i].exp_wb);
      chk("tbl_wb_we", {15'd0, wb_we}, {15'd0, vecs[i].exp_we});
      chk("tbl_rs_data", rs_data, vecs[i].exp_rs);
      chk("tbl_rt_data", rt_data, vecs[i].exp_rt);
      tick();
      chk("tbl_wr_cnt", wr_cnt, vecs[i].exp_wr);
    end

    // Memory writeback to R3 with same-cycle bypass.
    do_reset();
    drive(0, 1, 1, 0, 0, 3'd3, 16'h0000, 16'hBEEF, 16'h0000, 3'd3, 3'd0);
    #1;
    chk("beef_bypass", rs_data, 16'hBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd3);
    #1;
    chk("beef_r3", rs_data, 16'hBEEF);
    chk("beef_wr_cnt", wr_cnt, 16'd1);
    tick();

    // Link value wins over memory data.
    drive(0, 1, 1, 1, 0, 3'd7, 16'h0000, 16'h1111, 16'h0042, 3'd0, 3'd0);
    #1;
    chk("link_wb_data", wb_data, 16'h0042);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd7, 3'd7);
    #1;
    chk("link_r7", rt_data, 16'h0042);
    tick();

    // Same address on both ports under bypass.
    drive(0, 1, 0, 0, 0, 3'd5, 16'hA5A5, 16'h0000, 16'h0000, 3'd5, 3'd5);
    #1;
    chk("dual_rs", rs_data, 16'hA5A5);
    chk("dual_rt", rt_data, 16'hA5A5);
    tick();

    // Halt together with a write: write commits, then everything freezes.
    do_reset();
    drive(0, 1, 0, 0, 1, 3'd2, 16'h1234, 0, 0, 3'd2, 3'd0);
    tick();
    chk("halt_set", {15'd0, halted}, 16'd1);
    chk("halt_cyc", cycle_cnt, 16'd1);
    chk("halt_wr", wr_cnt, 16'd1);
    drive(0, 1, 0, 0, 0, 3'd2, 16'h5555, 0, 0, 3'd2, 3'd2);
    #1;
    chk("halt_we_blocked", {15'd0, wb_we}, 16'd0);
    chk("halt_r2_hold", rs_data, 16'h1234);
    tick();
    tick();
    chk("halt_r2_after", rt_data, 16'h1234);
    chk("halt_cyc_frozen", cycle_cnt, 16'd1);
    chk("halt_wr_frozen", wr_cnt, 16'd1);
    chk("halt_sticky", {15'd0, halted}, 16'd1);

    // Reset during a write to R1: write discarded, bypass still visible.
    drive(1, 1, 0, 0, 0, 3'd1, 16'h00FF, 0, 0, 3'd1, 3'd0);
    #1;
    chk("rst_we_blocked_by_halt", {15'd0, wb_we}, 16'd0);
    tick();
    drive(1, 1, 0, 0, 0, 3'd1, 16'h00FF, 0, 0, 3'd1, 3'd0);
    #1;
    chk("rst_bypass", rs_data, 16'h00FF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd1);
    #1;
    chk("rst_r1_cleared", rs_data, 16'h0000);
    chk("rst_wr_cnt", wr_cnt, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    tick();

    // Randomized traffic with occasional reset and halt.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 79) == 0), 3'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 3'($urandom), 3'($urandom));
      tick();
    end

    // Cycle counter wrap.
    do_reset();
    for (int n = 0; n < 65535; n++) begin
      tick();
    end
    chk("wrap_ffff", cycle_cnt, 16'hFFFF);
    tick();
    chk("wrap_zero", cycle_cnt, 16'h0000);
    chk("wrap_halted", {15'd0, halted}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile_stage.md
WB_REGFILE_STAGE -- requirements
Module: wb_regfile_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (all state updates on its rising edge) and rst (synchronous, active-high).
REQ-002 The ports SHALL be as follows:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- REGWRITE_wb  in  1  write enable from the MEM/WB register
- MEMTOREG_wb  in  1  select memory data for writeback
- TOWRITEDATA_wb  in  1  select link value (pc_add2_wb) for writeback
- HALT_wb  in  1  halt instruction retiring
- Rd_wb  in  3  destination register
- alu_out_wb, memData_out_wb, pc_add2_wb  in  16 each  writeback candidates
- rs_addr, rt_addr  in  3 each  decode read addresses
- rs_data, rt_data  out  16 each  decode read data (bypassed)
- wb_data  out  16  selected writeback value, for EX forwarding
- wb_we  out  1  effective write enable, for the forwarding unit
- halted  out  1  sticky halt flag
- cycle_cnt  out  16  cycles since reset, frozen when halted
- wr_cnt  out  16  register writes committed since reset

Function
REQ-003 wb_data SHALL be pc_add2_wb when TOWRITEDATA_wb=1; else memData_out_wb when MEMTOREG_wb=1; else alu_out_wb (TOWRITEDATA has priority).
REQ-004 wb_we SHALL equal REGWRITE_wb AND NOT halted; wb_data and wb_we SHALL be combinational, with zero latency.
REQ-005 The register file SHALL hold 8 x 16-bit registers, all writable, R0 included.
REQ-006 On a rising clk edge with wb_we=1, register[Rd_wb] SHALL take wb_data.
REQ-007 Reads SHALL be combinational.
REQ-008 rs_data SHALL equal wb_data when wb_we=1 and rs_addr==Rd_wb, else register[rs_addr]; rt_data SHALL follow the same rule with rt_addr (write-before-read bypass).
REQ-009 When rs_addr==rt_addr, both read ports SHALL return identical values, including under bypass.
REQ-010 halted SHALL set at the edge where HALT_wb=1 and remain set until rst.
REQ-011 If HALT_wb and REGWRITE_wb are both 1 in the same cycle while halted=0, the write SHALL commit.
REQ-012 Once halted=1, all register writes and counter updates SHALL be suppressed.
REQ-013 cycle_cnt SHALL increment by 1 each cycle while halted=0, including the cycle in which HALT_wb is sampled, then freeze; it SHALL wrap 0xFFFF->0x0000 without a flag.
REQ-014 wr_cnt SHALL increment by 1 on each edge with wb_we=1 and SHALL wrap modulo 2^16.
REQ-015 A bubble (all control inputs 0) SHALL cause no write and no wr_cnt change.

Reset
REQ-016 At a rising edge with rst=1: all 8 registers SHALL become 0x0000, halted=0, cycle_cnt=0, wr_cnt=0; rst SHALL take priority over every other input.
REQ-017 rst asserted in the same cycle as a write or halt SHALL discard that write or halt.
REQ-018 While rst=1, read outputs SHALL reflect the register contents (0x0000 after the first reset edge), with the bypass still active combinationally.

Structure
REQ-019 The register-array-plus-bypass logic SHALL be a single sub-module, regfile_bypass (8x16, two read ports, one write port), built from the team's dff_pipe cells with flush and stall tied to 0.
REQ-020 The shared package SHALL hold REG_W=16, REG_ADDR_W=3, NUM_REGS=8 and the writeback-select encoding constants; the counter width SHALL be taken from REG_W.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset, then read all 8 registers -> every register reads 0x0000; halted=0; counters=0.
- REGWRITE_wb=1, MEMTOREG_wb=1, Rd_wb=3, memData_out_wb=0xBEEF, rs_addr=3 in the same cycle -> rs_data=0xBEEF combinationally; after the edge R3=0xBEEF and wr_cnt=1.
- TOWRITEDATA_wb=1, MEMTOREG_wb=1, pc_add2_wb=0x0042, memData_out_wb=0x1111, Rd_wb=7 -> wb_data=0x0042; R7=0x0042.
- HALT_wb=1 together with a write of 0x1234 to R2 -> R2=0x1234 and halted=1; the next write of 0x5555 to R2 -> wb_we=0, R2 stays 0x1234, wr_cnt and cycle_cnt frozen.
- 65536 cycles without halt -> cycle_cnt wraps to 0x0000; rst asserted during a write to R1 of 0x00FF -> R1=0x0000.
- rs_addr=rt_addr=5 with a bypassed write of 0xA5A5 -> rs_data=rt_data=0xA5A5.
